dmem_port_arbiter: RTL and testbench
====================================

# dmem_port_arbiter

Shares the single data-memory port between the pipeline MEM stage and a DMA/loader burst master. It sits between the memory stage's load/store request and the data memory, and drives the memory's read strobe, write strobe, address and write data. It generates the pipeline stall and routes pipelined read data back to the owning requester.

## Interface
- RD_LAT, 1, data-memory read latency in cycles (legal 1..3)
- MAX_BURST, 16, maximum DMA burst length in beats
- STARVE_LIM, 4, consecutive DMA-blocked cycles before DMA is guaranteed one beat
- clk  in  1  system clock; one clock; reset is synchronous and active-high
- rst_  in  1  synchronous, active-high reset
- cpu_req  in  1  MEM-stage access request (memRd|memWrt)
- cpu_we  in  1  1=store, 0=load
- cpu_addr  in  32  byte address
- cpu_wdata  in  32  store data
- cpu_stall  out  1  freeze pipeline (IF..MEM)
- cpu_rvalid  out  1  load data valid pulse
- cpu_rdata  out  32  load data
- dma_req  in  1  burst request; held until dma_done
- dma_we  in  1  burst direction; 1=write
- dma_addr  in  32  burst start byte address, word aligned
- dma_len  in  5  beats, 1..MAX_BURST; 0 treated as 1
- dma_wdata  in  32  current write beat data
- dma_wready  out  1  write beat consumed this cycle
- dma_rvalid  out  1  read beat data valid
- dma_rdata  out  32  read beat data
- dma_busy  out  1  burst latched and not yet done
- dma_done  out  1  one-cycle pulse at burst completion
- mem_rd  out  1  to data memory memRd
- mem_wrt  out  1  to data memory memWrt
- mem_addr  out  32  to data memory addr
- mem_wdata  out  32  to data memory dataIn
- mem_rdata  in  32  from data memory dataOut, valid RD_LAT cycles after mem_rd

## Operation
- States: IDLE, BURST, DRAIN.
- IDLE -> BURST when dma_req=1: latch dma_we, dma_addr, dma_len into beat address and remaining count; dma_busy=1 from the next cycle.
- BURST: one beat issued per cycle when DMA owns the port. Beat address increments by 4 and wraps mod 2^32. Count decrements per beat.
- After the last beat: a write burst goes to IDLE with dma_done in the same cycle as the last beat. A read burst goes to DRAIN.
- DRAIN -> IDLE when the final DMA read response returns. dma_done is asserted with that last dma_rvalid.
- Per-cycle ownership:
  - CPU wins when cpu_req=1.
  - Exception: DMA wins when the starve counter has reached STARVE_LIM and a DMA beat is pending. Winning clears the counter.
  - The starve counter increments in each cycle where the CPU wins while a DMA beat is pending. It saturates at STARVE_LIM. It clears in IDLE.
- A CPU store that wins is performed in that cycle with no stall. A CPU load that wins issues mem_rd; cpu_stall=1 until cpu_rvalid.
- A CPU request that loses keeps cpu_stall=1 and is retried every cycle (inputs held by the stalled pipeline).
- While a CPU load is outstanding, no new CPU request is accepted (pipeline frozen). DMA beats may still issue during that wait.
- Read routing:
  - Each mem_rd pushes {valid, owner} into an RD_LAT-deep tag pipe.
  - At the pipe output, mem_rdata is steered to cpu_rdata or dma_rdata and the matching rvalid is pulsed.
  - rdata outputs hold their last value otherwise.
- mem_rd and mem_wrt are never both 1. When no requester owns the port, both are 0; mem_addr and mem_wdata hold their previous values.

## Timing
- Reset: all outputs 0, state IDLE, counters 0, tag pipe cleared (in-flight reads dropped). Reset mid-burst aborts without dma_done.
- Memory-side outputs are combinational from state, counters and requests. There is no added request latency.
- CPU load accepted in cycle N: mem_rd=1 at N; cpu_rvalid and cpu_rdata at N+RD_LAT; cpu_stall=1 over N..N+RD_LAT-1 and 0 at N+RD_LAT.
- CPU store accepted in cycle N: mem_wrt=1 at N; cpu_stall=0 at N.
- DMA write beat: dma_wready=1 in its issue cycle. The master advances dma_wdata on the next edge.
- DMA read beat issued at cycle M: dma_rvalid at M+RD_LAT. Reads are fully pipelined, so a burst with no CPU interference issues len beats in len consecutive cycles.
- dma_req=1 in the same cycle as dma_done does not start a new burst. A new burst is latched from IDLE on the following cycle.

## Structure
- Package dmem_arb_pkg: state enum (IDLE, BURST, DRAIN), owner encoding (OWN_CPU=0, OWN_DMA=1), MAX_BURST and the count width.
- Sub-module rd_tag_pipe: RD_LAT-stage shift register of {valid, owner}, cleared by rst_.

## Test plan
- RD_LAT=1, cpu_req load at 0x100 with mem returning 0xDEADBEEF -> mem_rd at N, cpu_stall=1 for exactly 1 cycle, cpu_rvalid with 0xDEADBEEF at N+1.
- DMA write, len=4 at 0x200, no CPU traffic -> mem_wrt on 4 consecutive cycles to 0x200/204/208/20C, 4 dma_wready pulses, dma_done on the 4th.
- DMA read, len=3, RD_LAT=2, with a CPU load in the 2nd beat cycle -> CPU wins that cycle. Tags route 3 rvalids to DMA and 1 to CPU with no mixing. dma_done with the last DMA rvalid.
- Continuous cpu_req stores during a len=8 DMA write -> a DMA beat is granted once every STARVE_LIM+1 cycles and the burst completes. Each blocked CPU cycle shows cpu_stall=1.
- DMA burst starting at 0xFFFFFFF8, len=3 -> addresses 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000. dma_len=0 -> exactly one beat.
- rst_ asserted mid read burst with 2 responses in flight -> next cycle all outputs 0, no rvalid or dma_done emitted, state IDLE.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory port arbiter.
package dmem_arb_pkg;

  typedef enum logic [1:0] {IDLE, BURST, DRAIN} state_e;

  typedef enum logic {OWN_CPU = 1'b0, OWN_DMA = 1'b1} owner_e;

  localparam int unsigned MAX_BURST = 16;
  localparam int unsigned CNT_W     = $clog2(MAX_BURST + 1);

  // One read-response tag travelling alongside the memory latency.
  typedef struct packed {
    logic   valid;
    owner_e owner;
  } rd_tag_t;

endpackage

// File: rtl/dmem_port_arbiter_if.sv
// Pipeline, DMA master and data-memory signals of the shared port.
interface dmem_port_arbiter_if;
  logic        cpu_req;
  logic        cpu_we;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic        cpu_stall;
  logic        cpu_rvalid;
  logic [31:0] cpu_rdata;

  logic        dma_req;
  logic        dma_we;
  logic [31:0] dma_addr;
  logic [4:0]  dma_len;
  logic [31:0] dma_wdata;
  logic        dma_wready;
  logic        dma_rvalid;
  logic [31:0] dma_rdata;
  logic        dma_busy;
  logic        dma_done;

  logic        mem_rd;
  logic        mem_wrt;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_stall, cpu_rvalid, cpu_rdata,
    input  dma_req, dma_we, dma_addr, dma_len, dma_wdata,
    output dma_wready, dma_rvalid, dma_rdata, dma_busy, dma_done,
    output mem_rd, mem_wrt, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_stall, cpu_rvalid, cpu_rdata,
    output dma_req, dma_we, dma_addr, dma_len, dma_wdata,
    input  dma_wready, dma_rvalid, dma_rdata, dma_busy, dma_done,
    input  mem_rd, mem_wrt, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/dmem_port_arbiter_rd_tag_pipe.sv
// Delay line carrying {valid, owner} of each memory read for DEPTH cycles.
module rd_tag_pipe
  import dmem_arb_pkg::*;
#(
  parameter int unsigned DEPTH = 1
) (
  input  logic    clk,
  input  logic    rst_,
  input  rd_tag_t i_tag,
  output rd_tag_t o_tag
);

  rd_tag_t r_pipe [DEPTH];

  always_ff @(posedge clk) begin
    if (rst_) begin
      for (int i = 0; i < int'(DEPTH); i++) r_pipe[i] <= '0;
    end else begin
      r_pipe[0] <= i_tag;
      for (int i = 1; i < int'(DEPTH); i++) r_pipe[i] <= r_pipe[i-1];
    end
  end

  assign o_tag = r_pipe[DEPTH-1];

endmodule

// File: rtl/dmem_port_arbiter.sv
// Shares the data-memory port between the MEM stage and a DMA burst master,
// with starvation protection for DMA and tagged routing of read responses.
module dmem_port_arbiter #(
  parameter int unsigned RD_LAT     = 1,
  parameter int unsigned MAX_BURST  = dmem_arb_pkg::MAX_BURST,
  parameter int unsigned STARVE_LIM = 4
) (
  input logic               clk,
  input logic               rst_,
  dmem_port_arbiter_if.slave bus
);
  import dmem_arb_pkg::*;

  localparam int unsigned CW = $clog2(MAX_BURST + 1);
  localparam int unsigned SW = $clog2(STARVE_LIM + 1);

  state_e          r_state;
  logic            r_we;
  logic [31:0]     r_addr;
  logic [CW-1:0]   r_cnt;
  logic [CW-1:0]   r_rsp_left;
  logic [SW-1:0]   r_starve;
  logic            r_ld_pend;
  logic [31:0]     r_addr_q;
  logic [31:0]     r_wdata_q;
  logic [31:0]     r_cpu_rdata;
  logic [31:0]     r_dma_rdata;

  logic [CW-1:0]   w_len;
  logic            w_dma_pend;
  logic            w_dma_force;
  logic            w_cpu_win;
  logic            w_dma_win;
  logic            w_last_beat;
  logic            w_cpu_rv;
  logic            w_dma_rv;
  rd_tag_t         w_push;
  rd_tag_t         w_pop;

  // Zero-length requests mean one beat; oversize requests are clamped.
  always_comb begin
    w_len = CW'(bus.dma_len);
    if (bus.dma_len == 5'd0)                     w_len = CW'(1);
    else if (32'(bus.dma_len) > MAX_BURST)       w_len = CW'(MAX_BURST);
  end

  // A pending CPU load freezes the pipeline, so its held request is ignored.
  always_comb begin
    w_dma_pend  = (r_state == BURST);
    w_dma_force = w_dma_pend && (r_starve >= SW'(STARVE_LIM));
    w_cpu_win   = bus.cpu_req && !r_ld_pend && !w_dma_force;
    w_dma_win   = w_dma_pend && !w_cpu_win;
    w_last_beat = w_dma_win && (r_cnt == CW'(1));
    w_cpu_rv    = w_pop.valid && (w_pop.owner == OWN_CPU);
    w_dma_rv    = w_pop.valid && (w_pop.owner == OWN_DMA);
  end

  always_comb begin
    bus.mem_rd    = 1'b0;
    bus.mem_wrt   = 1'b0;
    bus.mem_addr  = r_addr_q;
    bus.mem_wdata = r_wdata_q;
    if (w_cpu_win) begin
      bus.mem_rd   = !bus.cpu_we;
      bus.mem_wrt  = bus.cpu_we;
      bus.mem_addr = bus.cpu_addr;
      if (bus.cpu_we) bus.mem_wdata = bus.cpu_wdata;
    end else if (w_dma_win) begin
      bus.mem_rd   = !r_we;
      bus.mem_wrt  = r_we;
      bus.mem_addr = r_addr;
      if (r_we) bus.mem_wdata = bus.dma_wdata;
    end
  end

  always_comb begin
    w_push.valid = bus.mem_rd;
    w_push.owner = w_cpu_win ? OWN_CPU : OWN_DMA;
  end

  rd_tag_pipe #(.DEPTH(RD_LAT)) u_tag_pipe (
    .clk   (clk),
    .rst_  (rst_),
    .i_tag (w_push),
    .o_tag (w_pop)
  );

  always_comb begin
    bus.cpu_stall  = r_ld_pend ? !w_cpu_rv
                               : (bus.cpu_req && (!w_cpu_win || !bus.cpu_we));
    bus.cpu_rvalid = w_cpu_rv;
    bus.cpu_rdata  = w_cpu_rv ? bus.mem_rdata : r_cpu_rdata;
    bus.dma_rvalid = w_dma_rv;
    bus.dma_rdata  = w_dma_rv ? bus.mem_rdata : r_dma_rdata;
    bus.dma_wready = w_dma_win && r_we;
    bus.dma_busy   = (r_state != IDLE);
    bus.dma_done   = (w_last_beat && r_we)
                  || (w_dma_rv && !r_we && (r_rsp_left == CW'(1)));
  end

  always_ff @(posedge clk) begin
    if (rst_) begin
      r_state     <= IDLE;
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_cnt       <= '0;
      r_rsp_left  <= '0;
      r_starve    <= '0;
      r_ld_pend   <= 1'b0;
      r_addr_q    <= '0;
      r_wdata_q   <= '0;
      r_cpu_rdata <= '0;
      r_dma_rdata <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_starve <= '0;
          if (bus.dma_req) begin
            r_we       <= bus.dma_we;
            r_addr     <= bus.dma_addr;
            r_cnt      <= w_len;
            r_rsp_left <= w_len;
            r_state    <= BURST;
          end
        end
        BURST: begin
          if (w_dma_win) begin
            r_addr   <= r_addr + 32'd4;
            r_cnt    <= r_cnt - CW'(1);
            r_starve <= '0;
            if (w_last_beat) r_state <= r_we ? IDLE : DRAIN;
          end else if (w_cpu_win && (r_starve < SW'(STARVE_LIM))) begin
            r_starve <= r_starve + SW'(1);
          end
        end
        DRAIN: begin
          if (bus.dma_done) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase

      if (w_dma_rv) r_rsp_left <= r_rsp_left - CW'(1);

      if (w_cpu_rv)                      r_ld_pend <= 1'b0;
      else if (w_cpu_win && !bus.cpu_we) r_ld_pend <= 1'b1;

      r_addr_q  <= bus.mem_addr;
      r_wdata_q <= bus.mem_wdata;
      if (w_cpu_rv) r_cpu_rdata <= bus.mem_rdata;
      if (w_dma_rv) r_dma_rdata <= bus.mem_rdata;
    end
  end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed checks of dmem_port_arbiter with RD_LAT=2 and STARVE_LIM=4.
module tb_dmem_port_arbiter;

  localparam int unsigned L  = 2;
  localparam int unsigned SL = 4;

  logic clk  = 1'b0;
  logic rst_ = 1'b1;
  always #5 clk = ~clk;

  dmem_port_arbiter_if bus ();

  dmem_port_arbiter #(
    .RD_LAT     (L),
    .MAX_BURST  (16),
    .STARVE_LIM (SL)
  ) dut (
    .clk  (clk),
    .rst_ (rst_),
    .bus  (bus)
  );

  // Data memory: returns f(addr) L cycles after mem_rd.
  logic [31:0] rd_pipe [L];
  always_ff @(posedge clk) begin
    rd_pipe[0] <= bus.mem_rd ? bus.mem_addr : 32'h0;
    for (int i = 1; i < int'(L); i++) rd_pipe[i] <= rd_pipe[i-1];
  end

  function automatic logic [31:0] mem_val(input logic [31:0] a);
    return (a == 32'h100) ? 32'hDEAD_BEEF : (a ^ 32'hA5A5_0000);
  endfunction

  assign bus.mem_rdata = mem_val(rd_pipe[L-1]);

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  logic [31:0] wrap_exp [3];
  int          beat;
  logic        exp_dma;

  initial begin
    bus.cpu_req   = 1'b0;
    bus.cpu_we    = 1'b0;
    bus.cpu_addr  = 32'h0;
    bus.cpu_wdata = 32'h0;
    bus.dma_req   = 1'b0;
    bus.dma_we    = 1'b0;
    bus.dma_addr  = 32'h0;
    bus.dma_len   = 5'd0;
    bus.dma_wdata = 32'h0;
    wrap_exp[0] = 32'hFFFF_FFF8;
    wrap_exp[1] = 32'hFFFF_FFFC;
    wrap_exp[2] = 32'h0000_0000;

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    chk("rst cpu_stall",  32'(bus.cpu_stall),  32'h0);
    chk("rst cpu_rvalid", 32'(bus.cpu_rvalid), 32'h0);
    chk("rst cpu_rdata",  bus.cpu_rdata,       32'h0);
    chk("rst dma_wready", 32'(bus.dma_wready), 32'h0);
    chk("rst dma_rvalid", 32'(bus.dma_rvalid), 32'h0);
    chk("rst dma_rdata",  bus.dma_rdata,       32'h0);
    chk("rst dma_busy",   32'(bus.dma_busy),   32'h0);
    chk("rst dma_done",   32'(bus.dma_done),   32'h0);
    chk("rst mem_rd",     32'(bus.mem_rd),     32'h0);
    chk("rst mem_wrt",    32'(bus.mem_wrt),    32'h0);
    chk("rst mem_addr",   bus.mem_addr,        32'h0);
    chk("rst mem_wdata",  bus.mem_wdata,       32'h0);
    rst_ = 1'b0;

    // CPU load at 0x100
    @(negedge clk);
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 32'h100;
    #1;
    chk("ld N mem_rd",    32'(bus.mem_rd),    32'h1);
    chk("ld N mem_wrt",   32'(bus.mem_wrt),   32'h0);
    chk("ld N mem_addr",  bus.mem_addr,       32'h100);
    chk("ld N stall",     32'(bus.cpu_stall), 32'h1);
    @(negedge clk); #1;
    chk("ld N+1 mem_rd",  32'(bus.mem_rd),     32'h0);
    chk("ld N+1 stall",   32'(bus.cpu_stall),  32'h1);
    chk("ld N+1 rvalid",  32'(bus.cpu_rvalid), 32'h0);
    @(negedge clk); #1;
    chk("ld N+2 rvalid",  32'(bus.cpu_rvalid), 32'h1);
    chk("ld N+2 rdata",   bus.cpu_rdata,       32'hDEAD_BEEF);
    chk("ld N+2 stall",   32'(bus.cpu_stall),  32'h0);
    chk("ld N+2 mem_rd",  32'(bus.mem_rd),     32'h0);
    @(negedge clk);
    bus.cpu_req = 1'b0;
    #1;
    chk("ld after rvalid", 32'(bus.cpu_rvalid), 32'h0);
    chk("ld rdata hold",   bus.cpu_rdata,       32'hDEAD_BEEF);

    // CPU store
    @(negedge clk);
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 32'h40; bus.cpu_wdata = 32'h1234_5678;
    #1;
    chk("st mem_wrt",   32'(bus.mem_wrt),   32'h1);
    chk("st stall",     32'(bus.cpu_stall), 32'h0);
    chk("st mem_addr",  bus.mem_addr,       32'h40);
    chk("st mem_wdata", bus.mem_wdata,      32'h1234_5678);
    @(negedge clk);
    bus.cpu_req = 1'b0;
    #1;
    chk("idle mem_wrt",    32'(bus.mem_wrt), 32'h0);
    chk("idle mem_rd",     32'(bus.mem_rd),  32'h0);
    chk("idle addr hold",  bus.mem_addr,     32'h40);
    chk("idle wdata hold", bus.mem_wdata,    32'h1234_5678);

    // DMA write burst, len 4 at 0x200
    @(negedge clk);
    bus.dma_req = 1'b1; bus.dma_we = 1'b1; bus.dma_addr = 32'h200; bus.dma_len = 5'd4;
    bus.dma_wdata = 32'hA000_0000;
    #1;
    chk("dw latch mem_wrt", 32'(bus.mem_wrt),  32'h0);
    chk("dw latch busy",    32'(bus.dma_busy), 32'h0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.dma_wdata = 32'hA000_0000 + 32'(i);
      #1;
      chk("dw busy",   32'(bus.dma_busy),   32'h1);
      chk("dw wrt",    32'(bus.mem_wrt),    32'h1);
      chk("dw addr",   bus.mem_addr,        32'h200 + 32'(4 * i));
      chk("dw wdata",  bus.mem_wdata,       32'hA000_0000 + 32'(i));
      chk("dw wready", 32'(bus.dma_wready), 32'h1);
      chk("dw done",   32'(bus.dma_done),   (i == 3) ? 32'h1 : 32'h0);
    end
    @(negedge clk);
    bus.dma_req = 1'b0;
    #1;
    chk("dw end busy",   32'(bus.dma_busy),   32'h0);
    chk("dw end wready", 32'(bus.dma_wready), 32'h0);
    chk("dw end wrt",    32'(bus.mem_wrt),    32'h0);

    // DMA read len 3 at 0x300, CPU load in the second beat cycle
    @(negedge clk);
    bus.dma_req = 1'b1; bus.dma_we = 1'b0; bus.dma_addr = 32'h300; bus.dma_len = 5'd3;
    #1;
    @(negedge clk); #1;
    chk("dr c1 mem_rd",  32'(bus.mem_rd), 32'h1);
    chk("dr c1 addr",    bus.mem_addr,    32'h300);
    @(negedge clk);
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 32'h100;
    #1;
    chk("dr c2 cpu addr", bus.mem_addr,        32'h100);
    chk("dr c2 mem_rd",   32'(bus.mem_rd),     32'h1);
    chk("dr c2 stall",    32'(bus.cpu_stall),  32'h1);
    chk("dr c2 dvalid",   32'(bus.dma_rvalid), 32'h0);
    @(negedge clk); #1;
    chk("dr c3 addr",     bus.mem_addr,        32'h304);
    chk("dr c3 dvalid",   32'(bus.dma_rvalid), 32'h1);
    chk("dr c3 ddata",    bus.dma_rdata,       32'hA5A5_0300);
    chk("dr c3 cvalid",   32'(bus.cpu_rvalid), 32'h0);
    chk("dr c3 stall",    32'(bus.cpu_stall),  32'h1);
    @(negedge clk); #1;
    chk("dr c4 addr",     bus.mem_addr,        32'h308);
    chk("dr c4 cvalid",   32'(bus.cpu_rvalid), 32'h1);
    chk("dr c4 cdata",    bus.cpu_rdata,       32'hDEAD_BEEF);
    chk("dr c4 dvalid",   32'(bus.dma_rvalid), 32'h0);
    chk("dr c4 stall",    32'(bus.cpu_stall),  32'h0);
    @(negedge clk);
    bus.cpu_req = 1'b0;
    #1;
    chk("dr c5 dvalid",   32'(bus.dma_rvalid), 32'h1);
    chk("dr c5 ddata",    bus.dma_rdata,       32'hA5A5_0304);
    chk("dr c5 done",     32'(bus.dma_done),   32'h0);
    chk("dr c5 mem_rd",   32'(bus.mem_rd),     32'h0);
    chk("dr c5 busy",     32'(bus.dma_busy),   32'h1);
    @(negedge clk); #1;
    chk("dr c6 dvalid",   32'(bus.dma_rvalid), 32'h1);
    chk("dr c6 ddata",    bus.dma_rdata,       32'hA5A5_0308);
    chk("dr c6 done",     32'(bus.dma_done),   32'h1);
    chk("dr c6 cvalid",   32'(bus.cpu_rvalid), 32'h0);
    @(negedge clk);
    bus.dma_req = 1'b0;
    #1;
    chk("dr c7 busy",     32'(bus.dma_busy),   32'h0);
    chk("dr c7 dvalid",   32'(bus.dma_rvalid), 32'h0);
    chk("dr c7 ddata",    bus.dma_rdata,       32'hA5A5_0308);

    // Continuous CPU stores against a len 8 DMA write: DMA gets every 5th cycle
    @(negedge clk);
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 32'h80; bus.cpu_wdata = 32'h5555;
    bus.dma_req = 1'b1; bus.dma_we = 1'b1; bus.dma_addr = 32'h400; bus.dma_len = 5'd8;
    bus.dma_wdata = 32'hB0;
    #1;
    chk("sv c0 stall", 32'(bus.cpu_stall), 32'h0);
    chk("sv c0 wrt",   32'(bus.mem_wrt),   32'h1);
    chk("sv c0 addr",  bus.mem_addr,       32'h80);
    beat = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      bus.dma_wdata = 32'hB0 + 32'(beat);
      exp_dma = ((k % 5) == 0);
      #1;
      chk("sv wready", 32'(bus.dma_wready), 32'(exp_dma));
      chk("sv stall",  32'(bus.cpu_stall),  32'(exp_dma));
      chk("sv addr",   bus.mem_addr,  exp_dma ? (32'h400 + 32'(4 * beat)) : 32'h80);
      chk("sv wdata",  bus.mem_wdata, exp_dma ? (32'hB0 + 32'(beat)) : 32'h5555);
      chk("sv done",   32'(bus.dma_done),   (k == 40) ? 32'h1 : 32'h0);
      if (exp_dma) beat++;
    end
    @(negedge clk);
    bus.cpu_req = 1'b0; bus.dma_req = 1'b0;
    #1;
    chk("sv end busy", 32'(bus.dma_busy), 32'h0);

    // Address wrap, then dma_len=0 right after done
    @(negedge clk);
    bus.dma_req = 1'b1; bus.dma_we = 1'b1; bus.dma_addr = 32'hFFFF_FFF8; bus.dma_len = 5'd3;
    #1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      chk("wrap addr",   bus.mem_addr,        wrap_exp[i]);
      chk("wrap wready", 32'(bus.dma_wready), 32'h1);
      chk("wrap done",   32'(bus.dma_done),   (i == 2) ? 32'h1 : 32'h0);
    end
    @(negedge clk);
    bus.dma_addr = 32'h500; bus.dma_len = 5'd0;
    #1;
    chk("len0 latch busy", 32'(bus.dma_busy), 32'h0);
    chk("len0 latch wrt",  32'(bus.mem_wrt),  32'h0);
    @(negedge clk); #1;
    chk("len0 wrt",   32'(bus.mem_wrt),  32'h1);
    chk("len0 addr",  bus.mem_addr,      32'h500);
    chk("len0 done",  32'(bus.dma_done), 32'h1);
    @(negedge clk);
    bus.dma_req = 1'b0;
    #1;
    chk("len0 end busy", 32'(bus.dma_busy), 32'h0);
    chk("len0 end wrt",  32'(bus.mem_wrt),  32'h0);

    // Reset mid read burst with two responses in flight
    @(negedge clk);
    bus.dma_req = 1'b1; bus.dma_we = 1'b0; bus.dma_addr = 32'h600; bus.dma_len = 5'd4;
    #1;
    @(negedge clk); #1;
    chk("mr c1 mem_rd", 32'(bus.mem_rd), 32'h1);
    chk("mr c1 addr",   bus.mem_addr,    32'h600);
    @(negedge clk);
    rst_ = 1'b1;
    #1;
    chk("mr c2 addr",   bus.mem_addr,    32'h604);
    @(negedge clk);
    rst_ = 1'b0; bus.dma_req = 1'b0;
    #1;
    chk("mr c3 dvalid", 32'(bus.dma_rvalid), 32'h0);
    chk("mr c3 busy",   32'(bus.dma_busy),   32'h0);
    chk("mr c3 done",   32'(bus.dma_done),   32'h0);
    chk("mr c3 ddata",  bus.dma_rdata,       32'h0);
    chk("mr c3 cdata",  bus.cpu_rdata,       32'h0);
    chk("mr c3 mem_rd", 32'(bus.mem_rd),     32'h0);
    chk("mr c3 addr",   bus.mem_addr,        32'h0);
    @(negedge clk); #1;
    chk("mr c4 dvalid", 32'(bus.dma_rvalid), 32'h0);
    chk("mr c4 done",   32'(bus.dma_done),   32'h0);
    chk("mr c4 mem_rd", 32'(bus.mem_rd),     32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
